// File: rtl/fetch_unit.sv
// Two-stage instruction fetch front end: PC/request stage, F2 return stage,
// a one-entry hold buffer that absorbs the in-flight word during load stalls, and the ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_stall,
    input  logic        flush,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_pc;
    logic              r_f2_valid;
    logic [XLEN-1:0]   r_f2_pc;
    logic [XLEN-1:0]   r_hold_inst;
    logic [XLEN-1:0]   r_hold_pc;
    logic [XLEN-1:0]   r_id_inst;
    logic [XLEN-1:0]   r_id_pc;
    logic              r_id_valid;

    logic              w_hold_valid;
    logic              w_hold_capture;
    logic              w_imem_req;
    logic              w_id_load;
    logic [XLEN-1:0]   w_src_inst;
    logic [XLEN-1:0]   w_src_pc;
    logic              w_src_valid;
    logic [XLEN-1:0]   w_br_target;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect always abandons the hold buffer
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (load_stall && r_f2_valid) w_state_nxt = S_HOLD;
                S_HOLD:  if (!load_stall)              w_state_nxt = S_RUN;
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // Output/control decode: request strobe, hold capture and source select
    always_comb begin
        w_hold_valid   = (r_state == S_HOLD);
        w_imem_req     = rstn & ~flush & ~load_stall;
        w_id_load      = ~flush & ~load_stall;
        w_hold_capture = (r_state == S_RUN) & load_stall & ~flush & r_f2_valid;
        w_br_target    = br_addr & ~XLEN'(3);
        w_src_inst     = NOP_INST;
        w_src_pc       = r_f2_pc;
        w_src_valid    = 1'b0;
        if (w_hold_valid) begin
            w_src_inst  = r_hold_inst;
            w_src_pc    = r_hold_pc;
            w_src_valid = 1'b1;
        end else if (r_f2_valid) begin
            w_src_inst  = imem_rdata;
            w_src_pc    = r_f2_pc;
            w_src_valid = 1'b1;
        end
    end

    // PC and F2 tracking of the outstanding memory read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc       <= RESET_PC;
            r_f2_valid <= 1'b0;
            r_f2_pc    <= '0;
        end else begin
            r_f2_valid <= w_imem_req;
            if (flush) begin
                r_pc <= w_br_target;
            end else if (w_imem_req) begin
                r_pc    <= r_pc + XLEN'(4);
                r_f2_pc <= r_pc;
            end
        end
    end

    // Hold buffer payload; validity lives in the FSM state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
        end else if (w_hold_capture) begin
            r_hold_inst <= imem_rdata;
            r_hold_pc   <= r_f2_pc;
        end
    end

    // ID register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id_inst  <= NOP_INST;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (flush) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (w_id_load) begin
            r_id_inst  <= w_src_inst;
            r_id_pc    <= w_src_pc;
            r_id_valid <= w_src_valid;
        end
    end

    assign imem_req  = w_imem_req;
    assign imem_addr = r_pc;
    assign if_inst   = w_src_inst;
    assign if_pc     = w_src_pc;
    assign id_inst   = r_id_inst;
    assign id_pc     = r_id_pc;
    assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory, in-order scoreboard of
// expected ID program order, and point checks on stall, flush, wrap and reset behaviour.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        load_stall;
    logic        flush;
    logic [31:0] br_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    logic        m_ld;
    logic [31:0] m_e;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_stall (load_stall),
        .flush      (flush),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_valid   (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Instruction memory: data returns on the cycle after the request
    always @(posedge clk) begin
        imem_rdata <= imem_req ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    end

    // Scoreboard consumer plus the hold/F2 exclusivity invariant
    always @(posedge clk) begin
        m_ld = rstn && !load_stall && !flush;
        #1;
        check("inv_hold_f2", 32'(dut.w_hold_valid && dut.r_f2_valid), 32'd0);
        if (m_ld && id_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("sb_pc", id_pc, m_e);
                check("sb_inst", id_inst, inst_of(m_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Drive one cycle of stimulus and record the fetch it should cause
    task automatic drive(input logic st, input logic fl, input logic [31:0] br);
        load_stall = st;
        flush      = fl;
        br_addr    = br;
        if (fl) begin
            exp_q.delete();
            exp_pc = br & ~32'd3;
        end else if (!st && rstn) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        rstn = 1'b0; load_stall = 1'b0; flush = 1'b0; br_addr = '0;
        exp_pc = RESET_PC;
        repeat (3) tick();
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", id_inst, NOP_INST);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_hold", 32'(dut.w_hold_valid), 32'd0);

        // Reset release: sequential fetch
        rstn = 1'b1;
        drive(0, 0, 0); #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        tick();
        check("c1_id_valid", 32'(id_valid), 32'd0);
        drive(0, 0, 0); #1;
        check("c1_addr", imem_addr, 32'h4);
        tick();
        check("c2_id_valid", 32'(id_valid), 32'd1);
        check("c2_id_pc", id_pc, 32'h0);
        check("c2_id_inst", id_inst, inst_of(32'h0));
        drive(0, 0, 0); tick();
        drive(0, 0, 0); tick();
        drive(0, 0, 0); tick();

        // 3-cycle stall while F2 holds 0x10
        check("st_pre_id_pc", id_pc, 32'hC);
        drive(1, 0, 0); #1;
        check("st_req", 32'(imem_req), 32'd0);
        check("st_if_pc", if_pc, 32'h10);
        check("st_if_inst", if_inst, inst_of(32'h10));
        tick();
        for (int i = 0; i < 2; i++) begin
            check("st_id_pc_frozen", id_pc, 32'hC);
            check("st_id_valid", 32'(id_valid), 32'd1);
            drive(1, 0, 0); #1;
            check("st_req_n", 32'(imem_req), 32'd0);
            check("st_if_pc_n", if_pc, 32'h10);
            tick();
        end
        check("st_hold_valid", 32'(dut.w_hold_valid), 32'd1);
        drive(0, 0, 0); #1;
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h14);
        tick();
        check("rel_id_pc", id_pc, 32'h10);
        check("rel_id_inst", id_inst, inst_of(32'h10));
        drive(0, 0, 0); tick();
        check("rel_id_pc2", id_pc, 32'h14);
        check("rel_id_valid2", 32'(id_valid), 32'd1);

        // Flush to 0x203 while F2 holds 0x40
        while (exp_pc != 32'h44) begin
            drive(0, 0, 0); tick();
        end
        check("fl_f2_pc", dut.r_f2_pc, 32'h40);
        drive(0, 1, 32'h203); #1;
        check("fl_req", 32'(imem_req), 32'd0);
        tick();
        check("fl_id_valid1", 32'(id_valid), 32'd0);
        check("fl_id_inst", id_inst, NOP_INST);
        drive(0, 0, 0); #1;
        check("fl_addr", imem_addr, 32'h200);
        tick();
        check("fl_id_valid2", 32'(id_valid), 32'd0);
        drive(0, 0, 0); tick();
        check("fl_id_valid3", 32'(id_valid), 32'd1);
        check("fl_id_pc", id_pc, 32'h200);

        // Flush and stall together while in HOLD
        drive(1, 0, 0); tick();
        check("fs_hold_set", 32'(dut.w_hold_valid), 32'd1);
        drive(1, 1, 32'h300); #1;
        check("fs_req", 32'(imem_req), 32'd0);
        tick();
        check("fs_hold_clr", 32'(dut.w_hold_valid), 32'd0);
        check("fs_id_valid", 32'(id_valid), 32'd0);
        drive(0, 0, 0); #1;
        check("fs_addr", imem_addr, 32'h300);
        check("fs_req2", 32'(imem_req), 32'd1);
        tick();
        drive(0, 0, 0); tick();
        check("fs_id_pc", id_pc, 32'h300);
        check("fs_id_valid2", 32'(id_valid), 32'd1);

        // PC wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFC); tick();
        drive(0, 0, 0); #1;
        check("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0); #1;
        check("wr_addr_zero", imem_addr, 32'h0);
        tick();
        check("wr_id_pc_top", id_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0); tick();
        check("wr_id_pc_zero", id_pc, 32'h0);

        // Asynchronous reset while in HOLD
        drive(1, 0, 0); tick();
        check("rh_hold_set", 32'(dut.w_hold_valid), 32'd1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("rh_hold_clr", 32'(dut.w_hold_valid), 32'd0);
        check("rh_id_valid", 32'(id_valid), 32'd0);
        check("rh_req", 32'(imem_req), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        exp_pc = RESET_PC;
        drive(0, 0, 0); #1;
        check("rh_addr", imem_addr, RESET_PC);
        check("rh_req2", 32'(imem_req), 32'd1);
        tick();
        drive(0, 0, 0); tick();
        check("rh_id_valid2", 32'(id_valid), 32'd1);
        check("rh_id_pc", id_pc, RESET_PC);
        repeat (4) begin
            drive(0, 0, 0); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
